// File: rtl/param_counter.sv
// Up/down modulo counter with prescaler, parallel load, wrap/saturate mode,
// terminal-count pulse and active-low hex 7-segment decode of the count.
module param_counter #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned MODULUS  = 1024,
  parameter int unsigned PRESCALE = 50000000,
  parameter int unsigned NDIGITS  = 3
) (
  input  logic                 CLOCK_50,
  input  logic                 Resetn,
  input  logic                 En,
  input  logic                 Up,
  input  logic                 Load,
  input  logic [WIDTH-1:0]     D,
  input  logic                 Sat,
  output logic [WIDTH-1:0]     Q,
  output logic                 Tick,
  output logic                 TC,
  output logic [7*NDIGITS-1:0] HEX
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned HW = 4 * NDIGITS;
  localparam logic [WIDTH-1:0] QMAX    = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PLAST   = PW'(PRESCALE - 1);

  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;

  logic             tick_event;
  logic             at_bound;
  logic [WIDTH-1:0] d_clamped;

  always_comb begin
    tick_event = En && (presc_q == PLAST);
    at_bound   = Up ? (count_q == QMAX) : (count_q == '0);
    d_clamped  = (D > QMAX) ? QMAX : D;
  end

  // Load wins over a coincident tick event; the event is simply dropped.
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    if (Load) begin
      presc_d = '0;
      count_d = d_clamped;
    end else if (tick_event) begin
      presc_d = '0;
      tick_d  = 1'b1;
      tc_d    = at_bound;
      if (!at_bound) begin
        count_d = Up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end else if (!Sat) begin
        count_d = Up ? '0 : QMAX;
      end
    end else if (En) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      presc_q <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
    end
  end

  assign Q    = count_q;
  assign Tick = tick_q;
  assign TC   = tc_q;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Digits above the counter width decode zero-extended bits.
  logic [HW-1:0] q_ext;
  assign q_ext = HW'(count_q);

  for (genvar i = 0; i < int'(NDIGITS); i++) begin : g_digit
    assign HEX[7*i +: 7] = seg7(q_ext[4*i +: 4]);
  end

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench: one stimulus stream drives a PRESCALE=4 and a PRESCALE=1 counter,
// each checked cycle by cycle against an arithmetic reference model.
module tb_param_counter;

  localparam int M = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, en, up, load, sat;
  logic [3:0] d;
  logic [3:0] q0, q1;
  logic       tick0, tick1, tc0, tc1;
  logic [6:0] hex0, hex1;

  param_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4), .NDIGITS(1)) dut (
    .CLOCK_50(clk), .Resetn(resetn), .En(en), .Up(up), .Load(load), .D(d), .Sat(sat),
    .Q(q0), .Tick(tick0), .TC(tc0), .HEX(hex0)
  );

  param_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .NDIGITS(1)) dut1 (
    .CLOCK_50(clk), .Resetn(resetn), .En(en), .Up(up), .Load(load), .D(d), .Sat(sat),
    .Q(q1), .Tick(tick1), .TC(tc1), .HEX(hex1)
  );

  typedef struct packed {
    logic [3:0] q;
    logic       tick;
    logic       tc;
    logic [6:0] hex;
  } obs_t;

  obs_t sb0[$];
  obs_t sb1[$];
  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16];
  int mq[2];
  int mp[2];
  bit mtick[2];
  bit mtc[2];
  int ps[2];

  // Reference: p counts enabled cycles since the last tick/load/reset.
  function automatic void model_step(int k);
    mtick[k] = 1'b0;
    mtc[k]   = 1'b0;
    if (!resetn) begin
      mq[k] = 0;
      mp[k] = 0;
    end else if (load) begin
      mq[k] = (int'(d) > M - 1) ? M - 1 : int'(d);
      mp[k] = 0;
    end else if (en) begin
      mp[k] = mp[k] + 1;
      if (mp[k] == ps[k]) begin
        mp[k]    = 0;
        mtick[k] = 1'b1;
        if (up) begin
          if (mq[k] == M - 1) begin
            mtc[k] = 1'b1;
            if (!sat) mq[k] = 0;
          end else mq[k] = mq[k] + 1;
        end else begin
          if (mq[k] == 0) begin
            mtc[k] = 1'b1;
            if (!sat) mq[k] = M - 1;
          end else mq[k] = mq[k] - 1;
        end
      end
    end
  endfunction

  function automatic obs_t expected(int k);
    obs_t e;
    e.q    = 4'(mq[k]);
    e.tick = mtick[k];
    e.tc   = mtc[k];
    e.hex  = seg_tab[mq[k]];
    return e;
  endfunction

  task automatic step(input bit r, input bit e, input bit u, input bit l, input int dv,
                      input bit s);
    @(negedge clk);
    resetn = r;
    en     = e;
    up     = u;
    load   = l;
    d      = 4'(dv);
    sat    = s;
    model_step(0);
    model_step(1);
    sb0.push_back(expected(0));
    sb1.push_back(expected(1));
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void cmp_obs(string name, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got q=%0d tick=%0b tc=%0b hex=%h, expected q=%0d tick=%0b tc=%0b hex=%h",
               name, $time, act.q, act.tick, act.tc, act.hex, exp.q, exp.tick, exp.tc, exp.hex);
    end
  endfunction

  // Monitor: every cycle the counters present a new registered output.
  initial begin
    obs_t e0, e1;
    forever begin
      @(posedge clk);
      #1;
      if (sb0.size() > 0) begin
        e0 = sb0.pop_front();
        cmp_obs("sb_ps4", {q0, tick0, tc0, hex0}, e0);
      end
      if (sb1.size() > 0) begin
        e1 = sb1.pop_front();
        cmp_obs("sb_ps1", {q1, tick1, tc1, hex1}, e1);
      end
    end
  end

  initial begin
    int tcn;
    int bad;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    ps = '{4, 1};
    mq = '{0, 0};
    mp = '{0, 0};
    resetn = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; d = 4'd0; sat = 1'b0;

    // Reset held with En and Load asserted, then first tick after release.
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 5, 1'b0);
    sample();
    chk("rst_q", q0, 0);
    chk("rst_tick", tick0, 0);
    chk("rst_tc", tc0, 0);
    chk("rst_hex", hex0, 7'h40);
    chk("rst_q_ps1", q1, 0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      sample();
      if (i < 4) chk("first_tick_early", tick0, 0);
    end
    chk("first_tick", tick0, 1);
    chk("first_q", q0, 1);
    chk("first_hex", hex0, 7'h79);

    // Up wrap: 9 more ticks take Q 2..9 then 0.
    tcn = 0;
    bad = 0;
    for (int i = 0; i < 36; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      sample();
      if (tc0) begin
        tcn++;
        if (q0 != 4'd0 || !tick0) bad++;
      end
      if (q0 > 4'd9) bad++;
    end
    chk("up_wrap_tc_count", tcn, 1);
    chk("up_wrap_align", bad, 0);
    chk("up_wrap_q", q0, 0);

    // Down wrap from 0.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      sample();
    end
    chk("down_wrap_q", q0, 9);
    chk("down_wrap_tc", tc0, 1);

    // Saturate at the top: three ticks, three TC pulses, Q held.
    step(1'b1, 1'b1, 1'b1, 1'b1, 9, 1'b1);
    tcn = 0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
      sample();
      if (tc0) tcn++;
      if (tc0 != tick0 && tc0) bad++;
      if (q0 != 4'd9) bad++;
    end
    chk("sat_tc_count", tcn, 3);
    chk("sat_hold", bad, 0);

    // Load of 12 on a tick event clamps to 9 and restarts the period.
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 12, 1'b0);
    sample();
    chk("load_clamp_q", q0, 9);
    chk("load_tick", tick0, 0);
    chk("load_tc", tc0, 0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      sample();
      if (i < 4) chk("load_next_early", tick0, 0);
    end
    chk("load_next_tick", tick0, 1);
    chk("load_next_q", q0, 8);

    // Enable hold mid-period at P=2.
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      sample();
      if (tick0 || q0 != 4'd8) bad++;
    end
    chk("en_hold", bad, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    sample();
    chk("en_resume_early", tick0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    sample();
    chk("en_resume_tick", tick0, 1);
    chk("en_resume_q", q0, 7);

    // PRESCALE=1 counter: a tick every cycle, reset at Q=5.
    step(1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      sample();
      if (!tick1) bad++;
    end
    chk("ps1_tick_steady", bad, 0);
    chk("ps1_q5", q1, 5);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    sample();
    chk("ps1_rst_q", q1, 0);
    chk("ps1_rst_tick", tick1, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    sample();
    chk("ps1_resume_q", q1, 1);
    chk("ps1_resume_tick", tick1, 1);

    // Randomized traffic, checked by the scoreboard only.
    repeat (1500) begin
      step(1'($urandom_range(63) != 0), 1'($urandom_range(3) != 0), 1'($urandom_range(1)),
           1'($urandom_range(15) == 0), int'($urandom_range(15)), 1'($urandom_range(1)));
    end

    for (int i = 0; i < 10 && (sb0.size() > 0 || sb1.size() > 0); i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb0.size() + sb1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
